// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Requester IDs double as the grant encoding.
package dmem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic REQ_DCACHE = 1'b0;
    localparam logic REQ_ICACHE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone request wins outright,
// and on a tie the requester not served last wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one line-wide data memory port between dcache (m0) and icache (m1),
// one whole-line transaction at a time, with an optional per-transaction watchdog.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              timeout_o
);

    // A one-bit counter is kept when the watchdog is disabled so no zero-width vector exists.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic            WD_ON   = (TIMEOUT > 0);

    arb_state_e        state_q, state_d;
    logic              last_q, last_d;
    logic              grant_q, grant_d;
    logic              memEnable_q, memEnable_d;
    logic              memWrite_q, memWrite_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [DATA_W-1:0] memData_q, memData_d;
    logic [CNT_W-1:0]  wdCount_q, wdCount_d;
    logic              timeout_q, timeout_d;

    logic              pickValid;
    logic              pickWinner;
    logic [CNT_W-1:0]  wdNext;
    logic              wdExpire;

    rr_pick2 u_pick (
        .req    ({m1_enable_i, m0_enable_i}),
        .last   (last_q),
        .valid  (pickValid),
        .winner (pickWinner)
    );

    // Saturating so the count can never wrap back below the limit.
    assign wdNext   = (wdCount_q == CNT_MAX) ? wdCount_q : wdCount_q + 1'b1;
    assign wdExpire = WD_ON && (wdNext == CNT_MAX);

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        memEnable_d = memEnable_q;
        memWrite_d  = memWrite_q;
        memAddr_d   = memAddr_q;
        memData_d   = memData_q;
        wdCount_d   = '0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d     = BUSY;
                    grant_d     = pickWinner;
                    last_d      = pickWinner;
                    memEnable_d = 1'b1;
                    if (pickWinner == REQ_ICACHE) begin
                        memWrite_d = m1_write_i;
                        memAddr_d  = m1_addr_i;
                        memData_d  = m1_data_i;
                    end else begin
                        memWrite_d = m0_write_i;
                        memAddr_d  = m0_addr_i;
                        memData_d  = m0_data_i;
                    end
                end
            end
            BUSY: begin
                // An ack in the expiry cycle still completes the transaction normally.
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    memEnable_d = 1'b0;
                    memWrite_d  = 1'b0;
                end else if (wdExpire) begin
                    state_d     = IDLE;
                    memEnable_d = 1'b0;
                    memWrite_d  = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    wdCount_d = wdNext;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            grant_q     <= 1'b0;
            memEnable_q <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            wdCount_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            memEnable_q <= memEnable_d;
            memWrite_q  <= memWrite_d;
            memAddr_q   <= memAddr_d;
            memData_q   <= memData_d;
            wdCount_q   <= wdCount_d;
            timeout_q   <= timeout_d;
        end
    end

    assign mem_enable_o = memEnable_q;
    assign mem_write_o  = memWrite_q;
    assign mem_addr_o   = memAddr_q;
    assign mem_data_o   = memData_q;
    assign timeout_o    = timeout_q;

    assign m0_ack_o  = mem_ack_i & (state_q == BUSY) & (grant_q == REQ_DCACHE);
    assign m1_ack_o  = mem_ack_i & (state_q == BUSY) & (grant_q == REQ_ICACHE);
    assign m0_data_o = mem_data_i;
    assign m1_data_o = mem_data_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance without watchdog, one with TIMEOUT=8,
// both fed the same stimulus and checked every cycle against a transaction-level model.
module tb_dmem_arbiter;

    logic         clk;
    logic         rst_n;
    logic         m0En, m0Wr, m1En, m1Wr;
    logic [31:0]  m0Addr, m1Addr;
    logic [255:0] m0Din, m1Din;
    logic         memAck;
    logic [255:0] memDin;

    logic         memEn   [2];
    logic         memWr   [2];
    logic [31:0]  memAddr [2];
    logic [255:0] memDout [2];
    logic         m0Ack   [2];
    logic         m1Ack   [2];
    logic [255:0] m0Dout  [2];
    logic [255:0] m1Dout  [2];
    logic         tmo     [2];

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.DATA_W(256), .ADDR_W(32), .TIMEOUT(0)) dutNoWd (
        .clk_i(clk), .rst_i(rst_n),
        .m0_enable_i(m0En), .m0_write_i(m0Wr), .m0_addr_i(m0Addr), .m0_data_i(m0Din),
        .m0_ack_o(m0Ack[0]), .m0_data_o(m0Dout[0]),
        .m1_enable_i(m1En), .m1_write_i(m1Wr), .m1_addr_i(m1Addr), .m1_data_i(m1Din),
        .m1_ack_o(m1Ack[0]), .m1_data_o(m1Dout[0]),
        .mem_enable_o(memEn[0]), .mem_write_o(memWr[0]), .mem_addr_o(memAddr[0]),
        .mem_data_o(memDout[0]), .mem_ack_i(memAck), .mem_data_i(memDin),
        .timeout_o(tmo[0])
    );

    dmem_arbiter #(.DATA_W(256), .ADDR_W(32), .TIMEOUT(8)) dutWd (
        .clk_i(clk), .rst_i(rst_n),
        .m0_enable_i(m0En), .m0_write_i(m0Wr), .m0_addr_i(m0Addr), .m0_data_i(m0Din),
        .m0_ack_o(m0Ack[1]), .m0_data_o(m0Dout[1]),
        .m1_enable_i(m1En), .m1_write_i(m1Wr), .m1_addr_i(m1Addr), .m1_data_i(m1Din),
        .m1_ack_o(m1Ack[1]), .m1_data_o(m1Dout[1]),
        .mem_enable_o(memEn[1]), .mem_write_o(memWr[1]), .mem_addr_o(memAddr[1]),
        .mem_data_o(memDout[1]), .mem_ack_i(memAck), .mem_data_i(memDin),
        .timeout_o(tmo[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: who owns the port, how long it has waited, who went last.
    int           mBusy  [2];
    int           mOwner [2];
    int           mLast  [2];
    int           mWait  [2];
    logic         mTmo   [2];
    logic         mEn    [2];
    logic         mWr    [2];
    logic [31:0]  mAddr  [2];
    logic [255:0] mData  [2];
    int           pick;

    function automatic int limitOf(input int idx);
        return (idx == 0) ? 0 : 8;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mBusy[i] = 0; mOwner[i] = 0; mLast[i] = 1; mWait[i] = 0;
                mTmo[i] = 0; mEn[i] = 0; mWr[i] = 0; mAddr[i] = '0; mData[i] = '0;
            end else begin
                mTmo[i] = 0;
                if (mBusy[i] == 0) begin
                    pick = -1;
                    if (m0En && m1En) pick = 1 - mLast[i];
                    else if (m0En)    pick = 0;
                    else if (m1En)    pick = 1;
                    if (pick >= 0) begin
                        mBusy[i] = 1; mOwner[i] = pick; mLast[i] = pick; mWait[i] = 0;
                        mEn[i]   = 1;
                        mWr[i]   = (pick == 1) ? m1Wr : m0Wr;
                        mAddr[i] = (pick == 1) ? m1Addr : m0Addr;
                        mData[i] = (pick == 1) ? m1Din : m0Din;
                    end
                end else if (memAck) begin
                    mBusy[i] = 0; mEn[i] = 0; mWr[i] = 0;
                end else begin
                    mWait[i] = mWait[i] + 1;
                    if (limitOf(i) > 0 && mWait[i] >= limitOf(i)) begin
                        mBusy[i] = 0; mEn[i] = 0; mWr[i] = 0; mTmo[i] = 1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic expAck0, expAck1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            expAck0 = memAck && (mBusy[i] != 0) && (mOwner[i] == 0);
            expAck1 = memAck && (mBusy[i] != 0) && (mOwner[i] == 1);
            checkOutput($sformatf("dut%0d_mem_enable", i), 256'(memEn[i]), 256'(mEn[i]));
            checkOutput($sformatf("dut%0d_mem_write", i), 256'(memWr[i]), 256'(mWr[i]));
            checkOutput($sformatf("dut%0d_mem_addr", i), 256'(memAddr[i]), 256'(mAddr[i]));
            checkOutput($sformatf("dut%0d_mem_data", i), memDout[i], mData[i]);
            checkOutput($sformatf("dut%0d_m0_ack", i), 256'(m0Ack[i]), 256'(expAck0));
            checkOutput($sformatf("dut%0d_m1_ack", i), 256'(m1Ack[i]), 256'(expAck1));
            checkOutput($sformatf("dut%0d_m0_data", i), m0Dout[i], memDin);
            checkOutput($sformatf("dut%0d_m1_data", i), m1Dout[i], memDin);
            checkOutput($sformatf("dut%0d_timeout", i), 256'(tmo[i]), 256'(mTmo[i]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e0, input logic w0, input logic [31:0] a0,
                                 input logic [255:0] d0, input logic e1, input logic w1,
                                 input logic [31:0] a1, input logic [255:0] d1);
        m0En = e0; m0Wr = w0; m0Addr = a0; m0Din = d0;
        m1En = e1; m1Wr = w1; m1Addr = a1; m1Din = d1;
    endtask

    task automatic setAck(input logic a, input logic [255:0] d);
        memAck = a;
        memDin = d;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        setAck(0, '0);
        tick(2);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rst%0d_enable", i), 256'(memEn[i]), 256'(0));
            checkOutput($sformatf("rst%0d_addr", i), 256'(memAddr[i]), 256'(0));
            checkOutput($sformatf("rst%0d_timeout", i), 256'(tmo[i]), 256'(0));
        end
        rst_n = 1'b1;
    endtask

    logic [255:0] patA5, rd1, rd2, rd3;

    initial begin
        patA5 = {8{32'hA5A5_A5A5}};
        rd1   = {8{32'h1111_0001}};
        rd2   = {8{32'h2222_0002}};
        rd3   = {8{32'h3333_0003}};
        rst_n = 1'b0;
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        setAck(0, '0);

        $display("[TB] single dcache read");
        doReset();
        applyStimulus(1, 0, 32'h0000_0400, '0, 0, 0, 32'h0, '0);
        checkOutput("t1_en_before", 256'(memEn[0]), 256'(0));
        tick(1);
        checkOutput("t1_en_rise", 256'(memEn[0]), 256'(1));
        checkOutput("t1_addr", 256'(memAddr[0]), 256'(32'h400));
        checkOutput("t1_write", 256'(memWr[0]), 256'(0));
        tick(9);
        setAck(1, rd1);
        #1;
        checkOutput("t1_m0_ack", 256'(m0Ack[0]), 256'(1));
        checkOutput("t1_m1_ack", 256'(m1Ack[0]), 256'(0));
        checkOutput("t1_m0_data", m0Dout[0], rd1);
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        checkOutput("t1_en_drop", 256'(memEn[0]), 256'(0));
        tick(2);

        $display("[TB] simultaneous requests after reset");
        doReset();
        applyStimulus(1, 0, 32'h2000, '0, 1, 0, 32'h3000, '0);
        tick(1);
        checkOutput("t2_first_addr", 256'(memAddr[0]), 256'(32'h2000));
        tick(2);
        setAck(1, rd2);
        #1;
        checkOutput("t2_m0_ack", 256'(m0Ack[0]), 256'(1));
        checkOutput("t2_m1_noack", 256'(m1Ack[0]), 256'(0));
        tick(1);
        setAck(0, '0);
        m0En = 1'b0;
        checkOutput("t2_gap", 256'(memEn[0]), 256'(0));
        tick(1);
        checkOutput("t2_second_en", 256'(memEn[0]), 256'(1));
        checkOutput("t2_second_addr", 256'(memAddr[0]), 256'(32'h3000));
        tick(1);
        setAck(1, rd3);
        #1;
        checkOutput("t2_m1_ack", 256'(m1Ack[0]), 256'(1));
        checkOutput("t2_m0_noack", 256'(m0Ack[0]), 256'(0));
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        tick(2);

        $display("[TB] write-back then refill with icache pending");
        doReset();
        applyStimulus(1, 1, 32'h1000, patA5, 1, 0, 32'h5000, '0);
        tick(1);
        checkOutput("t3_wb_write", 256'(memWr[0]), 256'(1));
        checkOutput("t3_wb_addr", 256'(memAddr[0]), 256'(32'h1000));
        checkOutput("t3_wb_data", memDout[0], patA5);
        tick(1);
        setAck(1, '0);
        tick(1);
        setAck(0, '0);
        applyStimulus(1, 0, 32'h1000, '0, 1, 0, 32'h5000, '0);
        tick(1);
        checkOutput("t3_mid_addr", 256'(memAddr[0]), 256'(32'h5000));
        checkOutput("t3_mid_write", 256'(memWr[0]), 256'(0));
        setAck(1, rd1);
        #1;
        checkOutput("t3_m1_ack", 256'(m1Ack[0]), 256'(1));
        tick(1);
        setAck(0, '0);
        m1En = 1'b0;
        tick(1);
        checkOutput("t3_refill_en", 256'(memEn[0]), 256'(1));
        checkOutput("t3_refill_addr", 256'(memAddr[0]), 256'(32'h1000));
        checkOutput("t3_refill_write", 256'(memWr[0]), 256'(0));
        setAck(1, rd2);
        #1;
        checkOutput("t3_m0_ack", 256'(m0Ack[0]), 256'(1));
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        tick(2);

        $display("[TB] spurious ack while idle");
        doReset();
        setAck(1, rd3);
        #1;
        checkOutput("t4_m0_noack", 256'(m0Ack[0]), 256'(0));
        checkOutput("t4_m1_noack", 256'(m1Ack[0]), 256'(0));
        tick(1);
        setAck(0, '0);
        checkOutput("t4_still_idle", 256'(memEn[0]), 256'(0));
        applyStimulus(1, 0, 32'h6000, '0, 1, 0, 32'h6100, '0);
        tick(1);
        checkOutput("t4_tie_m0", 256'(memAddr[0]), 256'(32'h6000));
        setAck(1, rd1);
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        tick(2);

        $display("[TB] watchdog expiry with TIMEOUT=8");
        doReset();
        applyStimulus(0, 0, 32'h0, '0, 1, 0, 32'h7000, '0);
        tick(1);
        checkOutput("t5_en", 256'(memEn[1]), 256'(1));
        tick(7);
        checkOutput("t5_cycle8_tmo", 256'(tmo[1]), 256'(0));
        checkOutput("t5_cycle8_en", 256'(memEn[1]), 256'(1));
        tick(1);
        checkOutput("t5_tmo_pulse", 256'(tmo[1]), 256'(1));
        checkOutput("t5_en_drop", 256'(memEn[1]), 256'(0));
        checkOutput("t5_no_ack", 256'(m1Ack[1]), 256'(0));
        m1En = 1'b0;
        tick(1);
        checkOutput("t5_tmo_end", 256'(tmo[1]), 256'(0));
        applyStimulus(1, 0, 32'h8000, '0, 0, 0, 32'h0, '0);
        tick(1);
        checkOutput("t5_regrant_en", 256'(memEn[1]), 256'(1));
        checkOutput("t5_regrant_addr", 256'(memAddr[1]), 256'(32'h8000));
        setAck(1, rd2);
        #1;
        checkOutput("t5_regrant_ack", 256'(m0Ack[1]), 256'(1));
        checkOutput("t5_nowd_m1_ack", 256'(m1Ack[0]), 256'(1));
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        tick(2);

        $display("[TB] ack in the expiry cycle");
        doReset();
        applyStimulus(1, 0, 32'hB000, '0, 0, 0, 32'h0, '0);
        tick(8);
        setAck(1, rd3);
        #1;
        checkOutput("t5b_ack", 256'(m0Ack[1]), 256'(1));
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        checkOutput("t5b_no_tmo", 256'(tmo[1]), 256'(0));
        checkOutput("t5b_en_drop", 256'(memEn[1]), 256'(0));
        tick(2);

        $display("[TB] reset while busy");
        doReset();
        applyStimulus(1, 1, 32'h9000, patA5, 0, 0, 32'h0, '0);
        tick(2);
        #2;
        rst_n = 1'b0;
        setAck(1, rd1);
        #1;
        checkOutput("t6_en", 256'(memEn[0]), 256'(0));
        checkOutput("t6_write", 256'(memWr[0]), 256'(0));
        checkOutput("t6_addr", 256'(memAddr[0]), 256'(0));
        checkOutput("t6_data", memDout[0], 256'(0));
        checkOutput("t6_ack", 256'(m0Ack[0]), 256'(0));
        setAck(0, '0);
        applyStimulus(1, 0, 32'h9000, '0, 1, 0, 32'hA000, '0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        checkOutput("t6_tie_m0", 256'(memAddr[0]), 256'(32'h9000));
        setAck(1, rd2);
        #1;
        checkOutput("t6_m0_ack", 256'(m0Ack[0]), 256'(1));
        tick(1);
        setAck(0, '0);
        applyStimulus(0, 0, 32'h0, '0, 0, 0, 32'h0, '0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single 256-bit line-wide data memory port between the data cache and the instruction cache. It sits between both caches' memory interfaces and the data memory model. It serialises whole line transactions (read refill or dirty write-back), round-robin on contention, and routes the memory acknowledge back to the granted requester only.

## Interface
- DATA_W, 256, line width in bits
- ADDR_W, 32, byte address width
- TIMEOUT, 0, watchdog limit in cycles per transaction; 0 disables
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- m0_enable_i  in  1  requester 0 (dcache) transaction request, level
- m0_write_i  in  1  requester 0: 1 = write line, 0 = read line
- m0_addr_i  in  ADDR_W  requester 0 line address
- m0_data_i  in  DATA_W  requester 0 write data
- m0_ack_o  out  1  requester 0 completion pulse
- m0_data_o  out  DATA_W  requester 0 read data
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_ack_o, m1_data_o: same as m0, requester 1 (icache)
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write strobe
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion pulse
- mem_data_i  in  DATA_W  memory read data
- timeout_o  out  1  one-cycle pulse when the watchdog fires

## Operation
- States: IDLE, BUSY.
- IDLE: if neither enable is high, stay. If only one is high, grant it. If both are high, grant the requester not granted last (round-robin pointer `last`; `last` resets to 1, so m0 wins the first tie).
- At the grant edge: latch `grant`, `mem_write_o`, `mem_addr_o`, `mem_data_o` from the winner; set `mem_enable_o`=1; update `last`; go to BUSY.
- BUSY: hold the latched command. The requester's inputs are not re-sampled, and a requester dropping enable does not abort.
  - On `mem_ack_i`=1: clear `mem_enable_o` and `mem_write_o`, go to IDLE.
- Ack routing: `m{g}_ack_o` = `mem_ack_i` & (state==BUSY) & (grant==g), combinational. The other requester's ack stays 0. `mem_ack_i` in IDLE is ignored.
- Read data: `m0_data_o` = `m1_data_o` = `mem_data_i` (broadcast). Only the acked requester consumes it.
- Watchdog (TIMEOUT>0): cycle counter cleared on entry to BUSY, incremented each BUSY cycle.
  - When it reaches TIMEOUT with no ack: pulse `timeout_o`, deassert `mem_enable_o`, go to IDLE.
  - No ack is sent to the requester in this case.
  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- Reset: state IDLE, `last`=1, `grant`=0, counter 0. All outputs are 0: `mem_enable_o`, `mem_write_o`, `mem_addr_o`, `mem_data_o`, both acks, `timeout_o`. A reset mid-transaction abandons it with no ack.

## Timing
- Request to `mem_enable_o`: 1 cycle. The enable is sampled high at edge N, and `mem_enable_o` is high after edge N.
- Ack latency: 0 cycles from `mem_ack_i` to `mX_ack_o`.
- `mem_enable_o` is low for at least one cycle between consecutive transactions. The IDLE cycle after an ack lets the requester's updated enable/addr settle before re-arbitration.
- Back-to-back requests by the same requester (e.g. write-back then refill) are re-arbitrated. A pending other requester wins that slot.
- Throughput: one transaction per (memory latency + 2) cycles.
- Simultaneous ack and timeout in the same cycle: the ack wins and `timeout_o` stays 0.

## Structure
- Shared package `dmem_arb_pkg`:
  - state enum (IDLE, BUSY)
  - requester ID constants REQ_DCACHE=0, REQ_ICACHE=1
- One sub-module, `rr_pick2`: combinational 2-way round-robin selector.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `valid`, `winner`.
- Top level holds the FSM, command latches, ack demux and watchdog.

## Test plan
- Single dcache read at 0x0000_0400, memory acks 10 cycles later:
  - `mem_enable_o` rises 1 cycle after request.
  - `mem_addr_o`=0x400 and `mem_write_o`=0.
  - `m0_ack_o` pulses with ack; `m1_ack_o` stays 0.
- Both enables rise the same cycle after reset:
  - m0 is served first, then m1.
  - `mem_enable_o` is low for exactly 1 cycle between the two transactions.
- m0 write-back (0x1000, data 0xA5..) followed by refill, while m1 is continuously requesting:
  - Order is m0 write, m1, m0 read.
- Spurious `mem_ack_i` in IDLE:
  - no `mX_ack_o`, no state change.
- TIMEOUT=8, memory never acks:
  - `timeout_o` pulses at BUSY cycle 8.
  - `mem_enable_o` drops and no requester ack is given.
  - The next request is granted normally.
- `rst_i` pulled low while BUSY:
  - all outputs go to 0 immediately.
  - After release, a tie is granted to m0.
